outer_product_mac: RTL and testbench

//  Pipelined, handshaked successor to the combinational outer-product multiplier.
//  - Each accepted beat multiplies every activation in_a[j] by every weight in_w[i].
//  - Products accumulate into a DIM_C x DIM_A array across a group of beats; in_last closes the group.
//  - The finished array is presented with valid/ready. Feeds the accumulation/readout stage of the LUT datapath.

---
 rtl/outer_product_mac_pkg.sv | 8 +
 rtl/outer_product_mac_if.sv | 23 ++
 rtl/outer_product_mac_cell.sv | 50 +++++
 rtl/outer_product_mac.sv | 82 ++++++++
 tb/tb_outer_product_mac.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/outer_product_mac_pkg.sv
// outer_product_mac_pkg: FSM state encoding and the accumulator width check shared by the MAC array.
package outer_product_mac_pkg;
    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    function automatic bit acc_width_ok(int iw, int ww, int aw);
        return aw >= iw + ww;
    endfunction
endpackage

// File: rtl/outer_product_mac_if.sv
// outer_product_mac_if: beat input and result output handshakes of the outer-product MAC.
interface outer_product_mac_if #(
    parameter int DIM_A        = 4,
    parameter int DIM_C        = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24
);
    logic                                          in_valid;
    logic                                          in_ready;
    logic                                          in_last;
    logic [DIM_A-1:0][INPUT_WIDTH-1:0]             in_a;
    logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]            in_w;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]    out_acc;
    logic                                          out_sat;

    modport master (output in_valid, in_last, in_a, in_w, out_ready,
                    input  in_ready, out_valid, out_acc, out_sat);
    modport slave  (input  in_valid, in_last, in_a, in_w, out_ready,
                    output in_ready, out_valid, out_acc, out_sat);
endinterface

// File: rtl/outer_product_mac_cell.sv
// opm_cell: one product register plus accumulator (load / add, clamping when ACC_SAT_EN is defined).
module opm_cell #(
    parameter int IW = 8,
    parameter int WW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          take,
    input  logic          p_v,
    input  logic          first,
    input  logic [IW-1:0] a,
    input  logic [WW-1:0] w,
`ifdef ACC_SAT_EN
    output logic          clamp,
`endif
    output logic [AW-1:0] acc
);
    logic [IW+WW-1:0] mul;
    logic [AW-1:0]    prod_q, prod_d, acc_q, acc_d;

    always_comb begin
        mul    = {{WW{1'b0}}, a} * {{IW{1'b0}}, w};
        prod_d = take ? AW'(mul) : prod_q;
`ifdef ACC_SAT_EN
        // One extra bit exposes the carry so an overflowing add pins at all-ones.
        clamp = 1'b0;
        acc_d = acc_q;
        if (p_v) begin
            logic [AW:0] sum;
            sum   = {1'b0, acc_q} + {1'b0, prod_q};
            clamp = !first && sum[AW];
            acc_d = first ? prod_q : (sum[AW] ? '1 : sum[AW-1:0]);
        end
`else
        acc_d = p_v ? (first ? prod_q : acc_q + prod_q) : acc_q;
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end

    assign acc = acc_q;
endmodule

// File: rtl/outer_product_mac.sv
// outer_product_mac: pipelined, handshaked outer-product multiply-accumulate over beat groups.
// Defining ACC_SAT_EN makes cells clamp on overflow and drives the sticky out_sat flag.
module outer_product_mac
    import outer_product_mac_pkg::*;
#(
    parameter int DIM_A        = 4,
    parameter int DIM_C        = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 24
) (
    input logic              clk,
    input logic              rst,
    outer_product_mac_if.slave bus
);
    if (!acc_width_ok(INPUT_WIDTH, WEIGHT_WIDTH, ACC_WIDTH)) begin : g_width_err
        $error("ACC_WIDTH must be at least INPUT_WIDTH+WEIGHT_WIDTH");
    end

    state_t state_q, state_d;
    logic   first_q, first_d, p_v_q, p_v_d;
    logic   accept, hs;
    logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] acc;

    always_comb begin
        bus.in_ready  = state_q == ACCUM;
        bus.out_valid = state_q == HOLD;
        accept        = bus.in_valid && bus.in_ready;
        hs            = bus.out_valid && bus.out_ready;
        p_v_d         = accept;
        first_d       = hs ? 1'b1 : (p_v_q ? 1'b0 : first_q);
        state_d       = state_q == ACCUM ? ((accept && bus.in_last) ? DRAIN : ACCUM) :
                        state_q == DRAIN ? HOLD :
                        (bus.out_ready ? ACCUM : HOLD);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ACCUM;
            first_q <= 1'b1;
            p_v_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            p_v_q   <= p_v_d;
        end

`ifdef ACC_SAT_EN
    logic [DIM_C-1:0][DIM_A-1:0] clamp;
    logic                        sat_q, sat_d;

    always_comb sat_d = hs ? 1'b0 : (sat_q || (|clamp));

    always_ff @(posedge clk or posedge rst)
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;

    assign bus.out_sat = sat_q;
`else
    assign bus.out_sat = 1'b0;
`endif

    for (genvar i = 0; i < DIM_C; i++) begin : g_row
        for (genvar j = 0; j < DIM_A; j++) begin : g_col
            opm_cell #(.IW(INPUT_WIDTH), .WW(WEIGHT_WIDTH), .AW(ACC_WIDTH)) u_cell (
                .clk   (clk),
                .rst   (rst),
                .take  (accept),
                .p_v   (p_v_q),
                .first (first_q),
                .a     (bus.in_a[j]),
                .w     (bus.in_w[i]),
`ifdef ACC_SAT_EN
                .clamp (clamp[i][j]),
`endif
                .acc   (acc[i][j])
            );
        end
    end

    assign bus.out_acc = acc;
endmodule

// File: tb/tb_outer_product_mac.sv
// tb_outer_product_mac: directed vectors with hand-computed results for a 2x2, 8/8/20 outer-product MAC.
module tb_outer_product_mac;
    localparam int DA = 2, DC = 2, IW = 8, WW = 8, AW = 20;
    localparam int WRAP17 = (17 * 65025) % (1 << AW);
    localparam int SAT17  = (1 << AW) - 1;
`ifdef ACC_SAT_EN
    localparam int EXP17 = SAT17;
    localparam int EXPSAT = 1;
`else
    localparam int EXP17 = WRAP17;
    localparam int EXPSAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    outer_product_mac_if #(.DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW),
                           .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

    outer_product_mac #(.DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW),
                        .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_grid(string tag, int e00, int e01, int e10, int e11);
        int e [2][2];
        e = '{'{e00, e01}, '{e10, e11}};
        for (int i = 0; i < DC; i++)
            for (int j = 0; j < DA; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), 64'(bus.out_acc[i][j]), 64'(e[i][j]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(int a0, int a1, int w0, int w1, bit last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_a[0]  = IW'(a0);
        bus.in_a[1]  = IW'(a1);
        bus.in_w[0]  = WW'(w0);
        bus.in_w[1]  = WW'(w1);
    endtask

    task automatic drain_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_a      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_sat", 64'(bus.out_sat), 0);
        check_grid("rst_acc", 0, 0, 0, 0);

        beat(3, 5, 2, 7, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("one_lat_valid", 64'(bus.out_valid), 0);
        check("one_drain_ready", 64'(bus.in_ready), 0);
        step();
        check("one_valid", 64'(bus.out_valid), 1);
        check("one_hold_ready", 64'(bus.in_ready), 0);
        check_grid("one_acc", 6, 10, 21, 35);
        drain_result();
        check("one_release", 64'(bus.out_valid), 0);

        for (int k = 0; k < 17; k++) begin
            beat(255, 255, 255, 255, k == 16);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("ovf_valid", 64'(bus.out_valid), 1);
        check_grid("ovf_acc", EXP17, EXP17, EXP17, EXP17);
        check("ovf_sat", 64'(bus.out_sat), 64'(EXPSAT));

        beat(9, 9, 9, 9, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_in_ready%0d", k), 64'(bus.in_ready), 0);
            check($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 1);
            check($sformatf("bp_acc%0d", k), 64'(bus.out_acc[1][1]), 64'(EXP17));
        end
        check_grid("bp_acc_end", EXP17, EXP17, EXP17, EXP17);
        bus.in_valid = 1'b0;
        drain_result();
        beat(1, 1, 1, 1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        check_grid("after_bp_acc", 1, 1, 1, 1);
        check("after_bp_sat", 64'(bus.out_sat), 0);
        drain_result();

        beat(1, 1, 1, 1, 1'b0);
        step();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready", 64'(bus.in_ready), 1);
        check("midrst_valid", 64'(bus.out_valid), 0);
        check_grid("midrst_acc", 0, 0, 0, 0);
        beat(2, 2, 2, 2, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        check_grid("midrst_result", 4, 4, 4, 4);
        drain_result();

        beat(1, 1, 1, 1, 1'b1);
        step();
        beat(9, 9, 9, 9, 1'b1);
        check("drain_ready", 64'(bus.in_ready), 0);
        step();
        check("drain_valid", 64'(bus.out_valid), 1);
        check_grid("drain_acc", 1, 1, 1, 1);
        drain_result();
        check("drain_back_ready", 64'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        step();
        check("late_valid", 64'(bus.out_valid), 1);
        check_grid("late_acc", 81, 81, 81, 81);
        drain_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
